// File: rtl/hsync_receiver.sv
// hsync_receiver: receive-side line-timing monitor.
// Samples an hsync stream once per pixel tick, tracks the pixel position
// inside each line, checks sync width and line length against the
// programmed porch widths, and reports lock, errors and measured widths.
`timescale 1ns/1ps
module hsync_receiver #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_LINES      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PixelClock,
  input  logic       hsync,
  input  logic [9:0] SynchPulse,
  input  logic [9:0] BackPorch,
  input  logic [9:0] ActiveVideo,
  input  logic [9:0] FrontPorch,
  output logic [9:0] xposition,
  output logic       ActiveRegion,
  output logic       LineStart,
  output logic       Locked,
  output logic       TimingError,
  output logic [9:0] MeasuredSync,
  output logic [9:0] MeasuredLine
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_LINES);
  localparam logic [9:0] PCOUNT_MAX  = 10'h3FF;

  state_t     state_q, state_d;
  logic       pc_q;
  logic       s_q, s_d;
  logic [9:0] pcount_q, pcount_d;
  logic [3:0] good_q, good_d;
  logic       errSeen_q, errSeen_d;
  logic [9:0] xpos_q, xpos_d;
  logic       active_q, active_d;
  logic       lineStart_q, lineStart_d;
  logic       locked_q, locked_d;
  logic       timingError_q, timingError_d;
  logic [9:0] measSync_q, measSync_d;
  logic [9:0] measLine_q, measLine_d;

  logic       tick;
  logic       sNow;
  logic       assertEdge;
  logic       deassertEdge;
  logic [9:0] pinc;
  logic [9:0] lineTotal;
  logic [9:0] winStart;
  logic [9:0] winEnd;
  logic       syncErr;
  logic       lineErr;
  logic       timeoutErr;

  assign tick         = PixelClock & ~pc_q;
  assign sNow         = hsync ^ SYNC_ACTIVE_LOW;
  assign assertEdge   = sNow & ~s_q;
  assign deassertEdge = ~sNow & s_q;
  assign pinc         = (pcount_q == PCOUNT_MAX) ? PCOUNT_MAX : pcount_q + 10'd1;
  assign lineTotal    = SynchPulse + BackPorch + ActiveVideo + FrontPorch;
  assign winStart     = SynchPulse + BackPorch;
  assign winEnd       = winStart + ActiveVideo;

  // Next-state logic: everything advances only on a pixel tick, pulses clear otherwise.
  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    pcount_d      = pcount_q;
    good_d        = good_q;
    errSeen_d     = errSeen_q;
    xpos_d        = xpos_q;
    active_d      = active_q;
    lineStart_d   = 1'b0;
    timingError_d = 1'b0;
    measSync_d    = measSync_q;
    measLine_d    = measLine_q;
    syncErr       = 1'b0;
    lineErr       = 1'b0;
    timeoutErr    = 1'b0;

    if (tick) begin
      s_d = sNow;
      case (state_q)
        HUNT: begin
          if (assertEdge) begin
            pcount_d  = 10'd0;
            errSeen_d = 1'b0;
            state_d   = TRACK;
          end
        end
        TRACK: begin
          pcount_d = pinc;
          if (deassertEdge) begin
            measSync_d = pinc;
            if (pinc != SynchPulse) begin
              syncErr   = 1'b1;
              errSeen_d = 1'b1;
              good_d    = 4'd0;
            end
          end
          if (assertEdge) begin
            measLine_d  = pinc;
            lineStart_d = 1'b1;
            pcount_d    = 10'd0;
            errSeen_d   = 1'b0;
            if (pinc == lineTotal && !errSeen_q) begin
              if (good_q != LOCK_TARGET) begin
                good_d = good_q + 4'd1;
              end
            end else begin
              lineErr = 1'b1;
              good_d  = 4'd0;
            end
          end else if (pinc == PCOUNT_MAX) begin
            timeoutErr = 1'b1;
            good_d     = 4'd0;
            pcount_d   = 10'd0;
            state_d    = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase

      timingError_d = syncErr | lineErr | timeoutErr;

      if (state_d == TRACK && pcount_d >= winStart && pcount_d < winEnd) begin
        active_d = 1'b1;
        xpos_d   = pcount_d - winStart;
      end else begin
        active_d = 1'b0;
        xpos_d   = 10'd0;
      end
    end

    locked_d = (good_d == LOCK_TARGET);
  end

  // State and output registers with asynchronous reset back to HUNT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      pc_q          <= 1'b0;
      s_q           <= 1'b1;
      pcount_q      <= 10'd0;
      good_q        <= 4'd0;
      errSeen_q     <= 1'b0;
      xpos_q        <= 10'd0;
      active_q      <= 1'b0;
      lineStart_q   <= 1'b0;
      locked_q      <= 1'b0;
      timingError_q <= 1'b0;
      measSync_q    <= 10'd0;
      measLine_q    <= 10'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= PixelClock;
      s_q           <= s_d;
      pcount_q      <= pcount_d;
      good_q        <= good_d;
      errSeen_q     <= errSeen_d;
      xpos_q        <= xpos_d;
      active_q      <= active_d;
      lineStart_q   <= lineStart_d;
      locked_q      <= locked_d;
      timingError_q <= timingError_d;
      measSync_q    <= measSync_d;
      measLine_q    <= measLine_d;
    end
  end

  assign xposition    = xpos_q;
  assign ActiveRegion = active_q;
  assign LineStart    = lineStart_q;
  assign Locked       = locked_q;
  assign TimingError  = timingError_q;
  assign MeasuredSync = measSync_q;
  assign MeasuredLine = measLine_q;

endmodule

// File: tb/tb_hsync_receiver.sv
// Testbench for hsync_receiver: table-driven per-tick vectors plus
// hand-written sequences for stall and asynchronous reset behaviour.
// Widths are SynchPulse=2, BackPorch=3, ActiveVideo=5, FrontPorch=2,
// so a line is 12 ticks and the active window is line ticks 5..9.
`timescale 1ns/1ps
module tb_hsync_receiver;

  logic       clock;
  logic       reset;
  logic       PixelClock;
  logic       hsync;
  logic [9:0] SynchPulse;
  logic [9:0] BackPorch;
  logic [9:0] ActiveVideo;
  logic [9:0] FrontPorch;
  logic [9:0] xposition;
  logic       ActiveRegion;
  logic       LineStart;
  logic       Locked;
  logic       TimingError;
  logic [9:0] MeasuredSync;
  logic [9:0] MeasuredLine;

  typedef struct {
    logic       hs;
    logic       ls;
    logic       te;
    logic       ar;
    logic [9:0] x;
    logic       lk;
    int         ms;
    int         ml;
  } vec_t;

  vec_t vecs[$];
  int   checksTotal  = 0;
  int   checksPassed = 0;
  int   vecIdx       = 0;

  hsync_receiver #(.SYNC_ACTIVE_LOW(1'b1), .LOCK_LINES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .PixelClock  (PixelClock),
    .hsync       (hsync),
    .SynchPulse  (SynchPulse),
    .BackPorch   (BackPorch),
    .ActiveVideo (ActiveVideo),
    .FrontPorch  (FrontPorch),
    .xposition   (xposition),
    .ActiveRegion(ActiveRegion),
    .LineStart   (LineStart),
    .Locked      (Locked),
    .TimingError (TimingError),
    .MeasuredSync(MeasuredSync),
    .MeasuredLine(MeasuredLine)
  );

  // 2 ns system clock.
  initial begin
    clock = 1'b0;
    forever #1 clock = ~clock;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input int act, input int exp);
    checksTotal++;
    if (act == exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic pushVec(input logic hs, input logic ls, input logic te, input logic ar,
                         input logic [9:0] x, input logic lk, input int ms, input int ml);
    vec_t v;
    v.hs = hs; v.ls = ls; v.te = te; v.ar = ar; v.x = x; v.lk = lk; v.ms = ms; v.ml = ml;
    vecs.push_back(v);
  endtask

  // One line of the tracked stream, ticks fromK..lineLen-1, counted from the sync assert edge.
  task automatic addLine(input int syncLen, input int lineLen, input logic ls0, input logic te0,
                         input logic lk0, input logic teD, input logic lkD, input int ml0,
                         input int fromK);
    for (int k = fromK; k < lineLen; k++) begin
      logic hs, ls, te, ar, lk;
      logic [9:0] x;
      hs = (k < syncLen) ? 1'b0 : 1'b1;
      ls = (k == 0) ? ls0 : 1'b0;
      te = (k == 0) ? te0 : ((k == syncLen) ? teD : 1'b0);
      lk = (k < syncLen) ? lk0 : lkD;
      ar = (k >= 5 && k <= 9);
      x  = ar ? 10'(k - 5) : 10'd0;
      pushVec(hs, ls, te, ar, x, lk, (k == syncLen) ? syncLen : -1, (k == 0) ? ml0 : -1);
    end
  endtask

  // Ticks where nothing should happen at all.
  task automatic addConst(input logic hs, input int n);
    for (int k = 0; k < n; k++) pushVec(hs, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, -1, -1);
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal($sformatf("v%0d LineStart", vecIdx), int'(LineStart), int'(v.ls));
    checkVal($sformatf("v%0d TimingError", vecIdx), int'(TimingError), int'(v.te));
    checkVal($sformatf("v%0d ActiveRegion", vecIdx), int'(ActiveRegion), int'(v.ar));
    checkVal($sformatf("v%0d xposition", vecIdx), int'(xposition), int'(v.x));
    checkVal($sformatf("v%0d Locked", vecIdx), int'(Locked), int'(v.lk));
    if (v.ms >= 0) checkVal($sformatf("v%0d MeasuredSync", vecIdx), int'(MeasuredSync), v.ms);
    if (v.ml >= 0) checkVal($sformatf("v%0d MeasuredLine", vecIdx), int'(MeasuredLine), v.ml);
  endtask

  // One 8 ns PixelClock period: high two clocks, low two clocks.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    hsync      = v.hs;
    PixelClock = 1'b1;
    @(negedge clock);
    checkOutput(v);
    @(negedge clock);
    PixelClock = 1'b0;
    if (v.ls || v.te)
      checkVal($sformatf("v%0d pulse_width", vecIdx), int'({LineStart, TimingError}), 0);
    @(negedge clock);
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      vecIdx = i;
      applyStimulus(vecs[i]);
    end
    vecs.delete();
  endtask

  initial begin
    reset       = 1'b1;
    PixelClock  = 1'b0;
    hsync       = 1'b1;
    SynchPulse  = 10'd2;
    BackPorch   = 10'd3;
    ActiveVideo = 10'd5;
    FrontPorch  = 10'd2;
    repeat (3) @(negedge clock);
    checkVal("reset outputs", int'({xposition, ActiveRegion, LineStart, Locked, TimingError}), 0);
    checkVal("reset MeasuredSync", int'(MeasuredSync), 0);
    checkVal("reset MeasuredLine", int'(MeasuredLine), 0);
    reset = 1'b0;

    // Clean stream: acquire, then lock on the second tracked edge.
    addConst(1'b1, 3);
    addLine(2, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    // Short sync pulse, then the tainted line is rejected, then relock.
    addLine(1, 12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12, 0);
    addLine(2, 12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    // A 13-tick line breaks lock.
    addLine(2, 13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    addLine(2, 12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    // Missing sync: timeout when the count reaches 1023, back to hunting.
    addLine(2, 1023, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    pushVec(1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, -1, -1);
    addConst(1'b1, 3);
    addLine(2, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    addLine(2, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    runTable();

    // PixelClock stalls mid-active video; hsync glitches are ignored without ticks.
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      hsync = (c >= 10 && c < 20) ? 1'b0 : 1'b1;
      checkVal($sformatf("stall%0d", c),
               int'({xposition, ActiveRegion, LineStart, TimingError, Locked}),
               int'({10'd1, 1'b1, 1'b0, 1'b0, 1'b1}));
    end
    addLine(2, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 7);
    addLine(2, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    addLine(2, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12, 0);
    runTable();

    // Asynchronous reset in the middle of active video.
    @(negedge clock);
    reset = 1'b1;
    #0.5;
    checkVal("async reset outputs", int'({xposition, ActiveRegion, Locked}), 0);
    checkVal("async reset measured", int'({MeasuredSync, MeasuredLine}), 0);
    hsync = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Sync already asserted at reset release is not an edge.
    addConst(1'b0, 8);
    addConst(1'b1, 4);
    addLine(2, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    addLine(2, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0);
    runTable();

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/hsync_receiver.md
Name: hsync_receiver

Overview:
- Receive-side counterpart of the line-timing generator. Monitors an incoming hsync stream, paced by PixelClock, and checks it against the programmed SynchPulse / BackPorch / ActiveVideo / FrontPorch widths.
- Recovers the pixel x position and active-video window, reports measured widths, and raises timing errors and a lock indication.
- Sits between the sync source and the pixel-consuming logic (ball/paddle renderers, self-check harnesses).

Parameters:
- SYNC_ACTIVE_LOW, 1, hsync asserted when low (1) or high (0).
- LOCK_LINES, 2, consecutive error-free complete lines required before Locked asserts (range 1..15).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- PixelClock  input  1  slow pixel-rate square wave; sampled in the clock domain.
- hsync  input  1  incoming horizontal sync.
- SynchPulse, BackPorch, ActiveVideo, FrontPorch  input  10 each  expected widths in pixel ticks; held static while not in reset.
- xposition  output  10  recovered active-video pixel index.
- ActiveRegion  output  1  high while the recovered position is inside active video.
- LineStart  output  1  one-clock pulse on each tracked sync assertion.
- Locked  output  1  timing locked.
- TimingError  output  1  one-clock pulse on any detected violation.
- MeasuredSync  output  10  last measured sync width.
- MeasuredLine  output  10  last measured line length.

Behaviour:
- Pixel tick:
  - PixelClock is registered each clock (pc_q).
  - tick = PixelClock & ~pc_q: a one-clock pulse after a rising edge of PixelClock.
  - All state below updates only on clocks with tick=1.
- Sync sampling:
  - s = hsync XOR SYNC_ACTIVE_LOW, i.e. 1 = asserted.
  - s_q holds s from the previous tick. Its reset value is 1, so a sync already asserted at reset release is not treated as an edge.
  - Assert edge: s & ~s_q. Deassert edge: ~s & s_q.
- Reset values:
  - xposition, MeasuredSync, MeasuredLine = 0.
  - ActiveRegion, LineStart, Locked, TimingError = 0.
  - Pixel counter pcount = 0, good-line count = 0, state = HUNT.
- State HUNT:
  - Outputs are held inactive.
  - On an assert edge: pcount <= 0, state <= TRACK. No length check is done and no LineStart is issued for this first edge.
- State TRACK, each tick:
  - pcount <= pcount+1, saturating at 1023.
  - Deassert edge: MeasuredSync <= pcount. If pcount != SynchPulse, pulse TimingError and clear the good-line count.
    - Example: a 2-tick pulse has ticks pcount 0,1 asserted and deasserts at pcount=2.
  - Assert edge:
    - MeasuredLine <= pcount, pulse LineStart, pcount <= 0.
    - Line is good when pcount == SynchPulse+BackPorch+ActiveVideo+FrontPorch (10-bit sum, overflow is a don't-care configuration) and no error occurred since the previous assert edge.
    - Good line: good count +1, saturating at LOCK_LINES.
    - Bad line: TimingError pulse, good count <= 0.
  - Timeout: if pcount reaches 1023 with no assert edge, pulse TimingError, clear Locked and the good count, state <= HUNT.
- Locked:
  - Registered; equals (good count == LOCK_LINES).
  - Drops the clock after any error.
- Active window:
  - ActiveRegion = 1 when state=TRACK and SynchPulse+BackPorch <= pcount < SynchPulse+BackPorch+ActiveVideo, using the post-increment pcount.
  - In that window xposition = pcount-(SynchPulse+BackPorch); outside it xposition = 0.
  - Both outputs are registered and update on the tick clock. They are independent of Locked.
- Pulse width: LineStart and TimingError are high for exactly one clock. A sync error and a line error on the same tick produce a single TimingError pulse.
- Reset: asserting reset mid-line returns every output to its reset value immediately (asynchronous). After release the block re-enters HUNT.

Test Plan:
All scenarios use SynchPulse=2, BackPorch=3, ActiveVideo=5, FrontPorch=2 (total 12), clock period 2 ns, PixelClock period 8 ns, SYNC_ACTIVE_LOW=1.
1. Clean stream (hsync low for 2 ticks, high for 10, repeated) -> LineStart once per 12 ticks; MeasuredSync=2, MeasuredLine=12; Locked rises after the 2nd tracked assert edge; xposition steps 0..4 with ActiveRegion high on 5 ticks per line; TimingError never asserts.
2. One line with a 1-tick sync pulse -> MeasuredSync=1, TimingError one-clock pulse at the deassert, Locked falls; Locked recovers after 2 further good lines.
3. One line of 13 ticks -> MeasuredLine=13, TimingError at that assert edge, Locked low, good count restarts.
4. hsync held high for more than 1023 ticks after lock -> TimingError at pcount=1023, Locked=0, state HUNT; next low edge resumes tracking without issuing LineStart.
5. hsync low at reset release -> no edge detected until hsync goes high then low; reset asserted mid-active video -> xposition=0, ActiveRegion=0, Locked=0 within the same clock.
6. PixelClock held static for 50 clocks -> no tick, so no state change and all outputs hold their values.
